cal_pulse_seq: RTL and testbench

//  Calibration pulse sequencer. On a START command it generates a burst of NPULSE

---
 rtl/cal_pulse_seq_if.sv | 52 +++++
 rtl/cal_pulse_seq.sv | 196 +++++++++++++++++++
 tb/tb_cal_pulse_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cal_pulse_seq_if.sv
// ---------------------------------------------------------------------------
// cal_pulse_seq_if
//   Command/status bundle for the calibration pulse sequencer.
//
//   Command side (driven by the controller, modport master):
//     start      1-cycle burst request
//     abort      terminate the running burst
//     sel_ext    0 = injection line, 1 = external line
//     npulse     pulses in the burst
//     delay      cycles from start to the first pulse
//     pwidth     high cycles per pulse (0 behaves as 1)
//     gap        low cycles between pulses (0 behaves as 1)
//
//   Status side (driven by the sequencer, modport slave):
//     inj_pls    injection pulse line
//     ext_pls    external pulse line
//     busy       burst in progress
//     done       1-cycle strobe on normal completion
//     pls_issued pulses issued in the current/last burst
// ---------------------------------------------------------------------------
interface cal_pulse_seq_if #(
    parameter int CNT_W = 12,
    parameter int GAP_W = 16,
    parameter int DLY_W = 8,
    parameter int PW_W  = 4
);

    logic             start;
    logic             abort;
    logic             sel_ext;
    logic [CNT_W-1:0] npulse;
    logic [DLY_W-1:0] delay;
    logic [PW_W-1:0]  pwidth;
    logic [GAP_W-1:0] gap;

    logic             inj_pls;
    logic             ext_pls;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pls_issued;

    modport master (
        output start, abort, sel_ext, npulse, delay, pwidth, gap,
        input  inj_pls, ext_pls, busy, done, pls_issued
    );

    modport slave (
        input  start, abort, sel_ext, npulse, delay, pwidth, gap,
        output inj_pls, ext_pls, busy, done, pls_issued
    );

endinterface

// File: rtl/cal_pulse_seq.sv
// ---------------------------------------------------------------------------
// cal_pulse_seq
//   Calibration pulse sequencer. A start request launches a burst of npulse
//   pulses on either the injection or the external line, after a programmable
//   start delay, with programmable pulse width and inter-pulse gap. Progress is
//   reported through busy, a done strobe and the running pulse count.
//
//   Ports:
//     clk   40 MHz system clock, all logic on the rising edge
//     rst   synchronous, active-high reset
//     bus   cal_pulse_seq_if.slave: command inputs and registered status
//           outputs (see the interface file for the signal list)
// ---------------------------------------------------------------------------
module cal_pulse_seq #(
    parameter int CNT_W = 12,
    parameter int GAP_W = 16,
    parameter int DLY_W = 8,
    parameter int PW_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    cal_pulse_seq_if.slave bus
);

    // One shared down-counter times the delay, high and low phases, so it
    // must be as wide as the widest of the three configuration fields.
    localparam int TMR_A = (GAP_W > DLY_W) ? GAP_W : DLY_W;
    localparam int TMR_W = (TMR_A > PW_W) ? TMR_A : PW_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HIGH,
        ST_LOW,
        ST_FIN
    } state_e;

    state_e           state_q,  state_d;
    logic [TMR_W-1:0] tmr_q,    tmr_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] npulse_q, npulse_d;
    logic [PW_W-1:0]  pwidth_q, pwidth_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic             sel_q,    sel_d;
    logic             inj_q,    inj_d;
    logic             ext_q,    ext_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Timer reload values: the timer holds "cycles remaining minus one", so a
    // zero width or gap loads 0 and therefore lasts exactly one cycle.
    logic [TMR_W-1:0] pw_load;
    logic [TMR_W-1:0] gap_load;
    logic [TMR_W-1:0] pw_load_in;
    logic [TMR_W-1:0] dly_load_in;
    logic [CNT_W-1:0] issued_inc;
    logic             first_high;
    logic [CNT_W-1:0] issued_now;

    always_comb begin
        pw_load     = (pwidth_q == '0) ? '0 : TMR_W'(pwidth_q) - TMR_W'(1);
        gap_load    = (gap_q == '0)    ? '0 : TMR_W'(gap_q) - TMR_W'(1);
        pw_load_in  = (bus.pwidth == '0) ? '0 : TMR_W'(bus.pwidth) - TMR_W'(1);
        dly_load_in = TMR_W'(bus.delay) - TMR_W'(1);
        issued_inc  = issued_q + CNT_W'(1);
        // The timer sits at its reload value only in the first high cycle,
        // which is where the pulse is counted.
        first_high  = (state_q == ST_HIGH) && (tmr_q == pw_load);
        issued_now  = first_high ? issued_inc : issued_q;
    end

    // Next-state logic. The status outputs are derived from the next state so
    // that they come straight out of flops and line up with the state.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        issued_d = issued_q;
        npulse_d = npulse_q;
        pwidth_d = pwidth_q;
        gap_d    = gap_q;
        sel_d    = sel_q;

        case (state_q)
            ST_IDLE: begin
                // Abort in the same cycle as start cancels the request.
                if (bus.start && !bus.abort) begin
                    npulse_d = bus.npulse;
                    pwidth_d = bus.pwidth;
                    gap_d    = bus.gap;
                    sel_d    = bus.sel_ext;
                    issued_d = '0;
                    if (bus.npulse == '0) begin
                        state_d = ST_FIN;
                    end else if (bus.delay == '0) begin
                        state_d = ST_HIGH;
                        tmr_d   = pw_load_in;
                    end else begin
                        state_d = ST_DELAY;
                        tmr_d   = dly_load_in;
                    end
                end
            end

            ST_DELAY: begin
                if (tmr_q == '0) begin
                    state_d = ST_HIGH;
                    tmr_d   = pw_load;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_HIGH: begin
                issued_d = issued_now;
                if (tmr_q == '0) begin
                    // With a one-cycle pulse the count increments and the
                    // end-of-burst decision happen in the same cycle, hence
                    // the comparison against the updated count.
                    if (issued_now == npulse_q) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOW;
                        tmr_d   = gap_load;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_LOW: begin
                if (tmr_q == '0) begin
                    state_d = ST_HIGH;
                    tmr_d   = pw_load;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; the pulse count is frozen
        // at whatever it showed when the abort arrived.
        if ((state_q != ST_IDLE) && bus.abort) begin
            state_d  = ST_IDLE;
            issued_d = issued_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
        inj_d  = (state_d == ST_HIGH) && !sel_d;
        ext_d  = (state_d == ST_HIGH) &&  sel_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            issued_q <= '0;
            npulse_q <= '0;
            pwidth_q <= '0;
            gap_q    <= '0;
            sel_q    <= 1'b0;
            inj_q    <= 1'b0;
            ext_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            issued_q <= issued_d;
            npulse_q <= npulse_d;
            pwidth_q <= pwidth_d;
            gap_q    <= gap_d;
            sel_q    <= sel_d;
            inj_q    <= inj_d;
            ext_q    <= ext_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.inj_pls    = inj_q;
    assign bus.ext_pls    = ext_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pls_issued = issued_q;

endmodule

// File: tb/tb_cal_pulse_seq.sv
// ---------------------------------------------------------------------------
// tb_cal_pulse_seq
//   Drives the sequencer with directed scenarios and randomized bursts and
//   compares every status output, every cycle, against a timeline model that
//   computes the expected waveform directly from the burst configuration.
// ---------------------------------------------------------------------------
module tb_cal_pulse_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cal_pulse_seq_if #(.CNT_W(12), .GAP_W(16), .DLY_W(8), .PW_W(4)) bus ();

    cal_pulse_seq #(.CNT_W(12), .GAP_W(16), .DLY_W(8), .PW_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit busy;
        bit done;
        bit inj;
        bit ext;
        int issued;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model of the running burst: start cycle plus effective configuration.
    bit mActive      = 1'b0;
    int mT0          = 0;
    int mN           = 0;
    int mD           = 0;
    int mPw          = 1;
    int mGap         = 1;
    bit mSel         = 1'b0;
    int mIdleIssued  = 0;

    // Offset (from the start cycle) of the first idle cycle after the burst.
    function automatic int burstEnd();
        if (mN == 0) return 2;
        return 2 + mD + (mN - 1) * (mPw + mGap) + mPw;
    endfunction

    // Expected outputs during cycle c, from the burst timeline arithmetic.
    function automatic exp_t modelAt(int c);
        exp_t e;
        int off, o, p, idx, ph;
        e.busy   = 1'b0;
        e.done   = 1'b0;
        e.inj    = 1'b0;
        e.ext    = 1'b0;
        e.issued = mIdleIssued;
        if (!mActive) return e;
        off = c - mT0;
        if (off <= 0) return e;
        if (off >= burstEnd()) begin
            e.issued = mN;
            return e;
        end
        e.busy = 1'b1;
        if (off == burstEnd() - 1) begin
            e.done   = 1'b1;
            e.issued = mN;
            return e;
        end
        o = off - 1 - mD;
        if (o < 0) begin
            e.issued = 0;
            return e;
        end
        p   = mPw + mGap;
        idx = o / p;
        ph  = o % p;
        e.issued = (ph == 0) ? idx : idx + 1;
        if (ph < mPw) begin
            e.inj = !mSel;
            e.ext = mSel;
        end
        return e;
    endfunction

    // Advance the model by the inputs applied during cycle cyc.
    task automatic modelAdvance(input bit st, input bit ab, input bit rs, input bit sel,
                                input int n, input int d, input int pw, input int g);
        exp_t cur;
        cur = modelAt(cyc);
        if (rs) begin
            mActive     = 1'b0;
            mIdleIssued = 0;
            return;
        end
        if (mActive && (cyc - mT0 >= burstEnd())) begin
            mActive     = 1'b0;
            mIdleIssued = mN;
        end
        if (cur.busy) begin
            if (ab) begin
                mActive     = 1'b0;
                mIdleIssued = cur.issued;
            end
        end else if (st && !ab) begin
            mActive     = 1'b1;
            mT0         = cyc;
            mN          = n;
            mD          = d;
            mPw         = (pw == 0) ? 1 : pw;
            mGap        = (g == 0) ? 1 : g;
            mSel        = sel;
            mIdleIssued = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, clock it, then check all outputs vs the model.
    task automatic applyStimulus(input bit st, input bit ab, input bit rs, input bit sel,
                                 input int n, input int d, input int pw, input int g);
        exp_t e;
        rst         = rs;
        bus.start   = st;
        bus.abort   = ab;
        bus.sel_ext = sel;
        bus.npulse  = 12'(n);
        bus.delay   = 8'(d);
        bus.pwidth  = 4'(pw);
        bus.gap     = 16'(g);
        modelAdvance(st, ab, rs, sel, n, d, pw, g);
        @(posedge clk);
        #1;
        cyc++;
        e = modelAt(cyc);
        checkOutput("busy",       int'(bus.busy),       int'(e.busy));
        checkOutput("done",       int'(bus.done),       int'(e.done));
        checkOutput("inj_pls",    int'(bus.inj_pls),    int'(e.inj));
        checkOutput("ext_pls",    int'(bus.ext_pls),    int'(e.ext));
        checkOutput("pls_issued", int'(bus.pls_issued), e.issued);
    endtask

    task automatic idleCycles(input int k);
        for (int i = 0; i < k; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int t0;
    int injHigh;

    initial begin
        // Reset
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("reset_busy",   int'(bus.busy), 0);
        checkOutput("reset_issued", int'(bus.pls_issued), 0);

        // Test 1 timing, with a second start mid-burst that must be ignored
        t0 = cyc;
        injHigh = 0;
        applyStimulus(1, 0, 0, 0, 3, 2, 2, 3);
        for (int i = 1; i <= 17; i++) begin
            if (i == 6) applyStimulus(1, 0, 0, 1, 7, 0, 1, 1);
            else        idleCycles(1);
            if (bus.inj_pls) injHigh++;
            if (cyc - t0 == 3)  checkOutput("t1_first_high", int'(bus.inj_pls), 1);
            if (cyc - t0 == 15) checkOutput("t1_done", int'(bus.done), 1);
        end
        checkOutput("t1_high_cycles", injHigh, 6);
        checkOutput("t1_issued", int'(bus.pls_issued), 3);

        // Test 2: single one-cycle pulse on the external line
        t0 = cyc;
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("t2_ext_high", int'(bus.ext_pls), 1);
        idleCycles(1);
        checkOutput("t2_done", int'(bus.done), 1);
        idleCycles(2);
        checkOutput("t2_issued", int'(bus.pls_issued), 1);

        // Test 3: zero-pulse burst
        applyStimulus(1, 0, 0, 0, 0, 3, 2, 2);
        checkOutput("t3_done", int'(bus.done), 1);
        idleCycles(1);
        checkOutput("t3_busy_clear", int'(bus.busy), 0);

        // Test 4: abort in the second high cycle of the 4th pulse
        t0 = cyc;
        applyStimulus(1, 0, 0, 0, 10, 1, 3, 2);
        for (int i = 1; i <= 17; i++) begin
            if (i == 5) applyStimulus(1, 0, 0, 1, 2, 0, 1, 1);
            else        idleCycles(1);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_busy",   int'(bus.busy), 0);
        checkOutput("t4_line",   int'(bus.inj_pls), 0);
        checkOutput("t4_issued", int'(bus.pls_issued), 4);
        idleCycles(4);

        // Test 5: start with abort in idle, then reset mid-gap, then rerun
        applyStimulus(1, 1, 0, 0, 3, 2, 2, 3);
        checkOutput("t5_dropped", int'(bus.busy), 0);
        applyStimulus(1, 0, 0, 0, 3, 2, 2, 3);
        idleCycles(5);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("t5_rst_busy",   int'(bus.busy), 0);
        checkOutput("t5_rst_issued", int'(bus.pls_issued), 0);
        applyStimulus(1, 0, 0, 0, 3, 2, 2, 3);
        idleCycles(16);
        checkOutput("t5_rerun_issued", int'(bus.pls_issued), 3);

        // Boundary: maximum pulse count with minimum timing
        applyStimulus(1, 0, 0, 1, 4095, 0, 0, 0);
        idleCycles(8195);
        checkOutput("max_issued", int'(bus.pls_issued), 4095);

        // Randomized bursts with occasional abort, stray start and reset
        for (int b = 0; b < 150; b++) begin
            exp_t e;
            applyStimulus(1, ($urandom % 16) == 0, 0, $urandom % 2,
                          $urandom_range(0, 6), $urandom_range(0, 4),
                          $urandom_range(0, 3), $urandom_range(0, 4));
            for (int k = 0; k < 100; k++) begin
                e = modelAt(cyc);
                if (!e.busy && k > 1) break;
                if (($urandom % 300) == 0)
                    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
                else if (($urandom % 40) == 0)
                    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
                else if (($urandom % 8) == 0)
                    applyStimulus(1, 0, 0, $urandom % 2, $urandom_range(0, 6),
                                  $urandom_range(0, 4), $urandom_range(0, 3),
                                  $urandom_range(0, 4));
                else
                    idleCycles(1);
            end
            idleCycles(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
